i2s_tx: RTL

//  I2S transmitter clocked by the audio master clock SND_MCLK (256*fs, 11.2896 MHz for 44.1 kHz).

---
 rtl/snd_pkg.sv | 14 +
 rtl/i2s_frame_cnt.sv | 51 +++++
 rtl/i2s_tx.sv | 110 +++++++++++
 3 files changed

// File: rtl/snd_pkg.sv
// Shared constants and helpers for the I2S transmitter slice.
package snd_pkg;

  localparam int unsigned SLOT_W     = 32;
  localparam int unsigned FRAME_BITS = 64;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/i2s_frame_cnt.sv
// Frame position counter for the I2S transmitter; parks at 0 while disabled and
// decodes bit-clock, word-clock, shift and load strobes from the next count.
module i2s_frame_cnt
  import snd_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bclk_next,
  output logic lrck_next,
  output logic shift_en,
  output logic load_en
);

  localparam int unsigned FRAME = FRAME_BITS * BCLK_DIV;
  localparam int unsigned CW    = clog2(FRAME);
  localparam int unsigned PW    = clog2(BCLK_DIV);

  logic [CW-1:0] c_q, c_d;
  logic [PW-1:0] ph_q, ph_d;

  // Bit phase runs alongside the frame count so no modulo is needed for any divider.
  always_comb begin
    c_d  = '0;
    ph_d = '0;
    if (en) begin
      c_d  = (c_q == CW'(FRAME - 1)) ? '0 : c_q + 1'b1;
      ph_d = (ph_q == PW'(BCLK_DIV - 1)) ? '0 : ph_q + 1'b1;
    end
  end

  always_comb begin
    bclk_next = (ph_d >= PW'(BCLK_DIV / 2));
    lrck_next = (c_d >= CW'(FRAME / 2));
    shift_en  = en && (ph_d == '0);
    load_en   = en && (c_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q  <= '0;
      ph_q <= '0;
    end else begin
      c_q  <= c_d;
      ph_q <= ph_d;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry sample holding register, 64-bit frame shift register
// and registered DAC pins, all timed from the SND_MCLK frame counter.
module i2s_tx
  import snd_pkg::*;
#(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic              SND_MCLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic [DATA_W-1:0] IN_L,
  input  logic [DATA_W-1:0] IN_R,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              SND_BCLK,
  output logic              SND_LRCK,
  output logic              SND_SDATA,
  output logic              FRAME_START,
  output logic              UNDERRUN
);

  localparam int unsigned PAD = SLOT_W - 1 - DATA_W;

  logic bclk_next, lrck_next, shift_en, load_en;

  i2s_frame_cnt #(
    .BCLK_DIV (BCLK_DIV)
  ) u_cnt (
    .clk       (SND_MCLK),
    .rst_n     (RST_N),
    .en        (EN),
    .bclk_next (bclk_next),
    .lrck_next (lrck_next),
    .shift_en  (shift_en),
    .load_en   (load_en)
  );

  logic                  full_q, full_d;
  logic [DATA_W-1:0]     hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic                  bclk_q, bclk_d, lrck_q, lrck_d;
  logic                  fs_q, fs_d, ur_q, ur_d;
  logic [SLOT_W-1:0]     l_slot, r_slot;
  logic                  wr;

  assign IN_READY = ~full_q;
  assign wr       = IN_VALID & ~full_q;

  // Delay bit, MSB-first sample, zero pad: shifting the zero-extended sample avoids a zero-width pad.
  always_comb begin
    l_slot = SLOT_W'({1'b0, hold_l_q}) << PAD;
    r_slot = SLOT_W'({1'b0, hold_r_q}) << PAD;
  end

  always_comb begin
    full_d   = full_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (load_en) full_d = 1'b0;
    if (wr) begin
      full_d   = 1'b1;
      hold_l_d = IN_L;
      hold_r_d = IN_R;
    end
  end

  always_comb begin
    sr_d = sr_q;
    if (!EN)          sr_d = '0;
    else if (load_en) sr_d = full_q ? {l_slot, r_slot} : '0;
    else if (shift_en) sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
  end

  always_comb begin
    bclk_d = EN & bclk_next;
    lrck_d = EN & lrck_next;
    fs_d   = load_en;
    ur_d   = load_en & ~full_q;
  end

  always_ff @(posedge SND_MCLK or negedge RST_N) begin
    if (!RST_N) begin
      full_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      sr_q     <= '0;
      bclk_q   <= 1'b0;
      lrck_q   <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      full_q   <= full_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      sr_q     <= sr_d;
      bclk_q   <= bclk_d;
      lrck_q   <= lrck_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
    end
  end

  assign SND_BCLK    = bclk_q;
  assign SND_LRCK    = lrck_q;
  assign SND_SDATA   = sr_q[FRAME_BITS-1];
  assign FRAME_START = fs_q;
  assign UNDERRUN    = ur_q;

endmodule
